uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receive engine; successor to the fixed 5–8 bit receiver used by the 16750 core.
- Word length up to MAX_DATA_BITS, five parity modes, 1/2 stop bits, 3-sample majority bit decision.
- Break detection with break-end wait; valid/ready output holding register with overrun reporting.
- Sits between the baud generator (RXCLK tick) and the RX FIFO / LSR logic.

Parameters:
OVERSAMPLE, 16, RXCLK ticks per bit; even, >=8
MAX_DATA_BITS, 9, widest supported word; 5..16
SYNC_STAGES, 2, SIN synchroniser depth; >=2

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
RXCLK  in  1  oversample tick, one-CLK pulse, OVERSAMPLE per bit
CLEAR  in  1  synchronous abort: state->IDLE, output register emptied
WLEN  in  5  data bits per word; legal 5..MAX_DATA_BITS, values outside clamp to nearest limit
PMODE  in  3  0 none, 1 odd, 2 even, 3 mark, 4 space, 5-7 treated as none
STOP2  in  1  1 = two stop bits checked
SIN  in  1  serial input, asynchronous
DOUT  out  MAX_DATA_BITS  received word, LSB-first assembly, zero-extended above WLEN
DVALID  out  1  DOUT/PE/FE/BI valid
DREADY  in  1  consumer accepts word when DVALID & DREADY
PE  out  1  parity error of held word
FE  out  1  framing error of held word
BI  out  1  break indication of held word
OVR  out  1  one-CLK pulse: completed frame dropped, holding register full
BUSY  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; DOUT 0; DVALID, PE, FE, BI, OVR 0; BUSY 0; tick and bit counters 0; synchroniser flops 1.
- SIN passes through SYNC_STAGES flops (sSIN); all decisions use sSIN.
- Tick counter 0..OVERSAMPLE-1 advances on RXCLK; wraps to 0 and advances the bit position at count OVERSAMPLE-1.
- Bit decision: M = OVERSAMPLE/2; samples at counts M-1, M, M+1; majority of three is the bit value; decision made on RXCLK at count M+1.
- WLEN, PMODE and STOP2 are latched on IDLE->START; changes mid-frame have no effect.
- States:
  - IDLE: counters cleared. sSIN==0 -> START.
  - START: majority 1 -> IDLE (false start, no output, no OVR). Majority 0 -> DATA at bit boundary.
  - DATA: one decision per bit into DOUT shadow position. After WLEN bits -> PARITY if PMODE in 1..4, else STOP.
  - PARITY: one decision -> STOP.
  - STOP: first stop decision; STOP2=1 -> STOP_B at bit boundary; STOP2=0 -> frame complete immediately at decision (no wait for end of stop bit).
  - STOP_B: second stop decision -> frame complete.
  - On frame complete: BI set -> BRK_WAIT, else IDLE.
  - BRK_WAIT: stay until sSIN==1 for one full CLK, then IDLE.
- Error rules:
  - odd: XOR(data, parity bit) must be 1; even: must be 0; mark: parity bit must be 1; space: must be 0.
  - FE = any checked stop decision 0.
  - BI = all data bits 0, parity bit 0 (if enabled), first stop decision 0. BI implies FE; PE evaluated normally.
- Output register:
  - Frame complete with DVALID==0, or DVALID&DREADY in the same cycle: next CLK load DOUT/PE/FE/BI, DVALID=1.
  - Frame complete otherwise: frame discarded, held word unchanged, OVR=1 next CLK for one cycle.
  - DVALID&DREADY with no load: DVALID=0 next CLK; DOUT and flags retain their values.
- Latency: DVALID rises 1 CLK after the RXCLK that makes the final stop decision.
- CLEAR: highest priority over all events. Next CLK: IDLE, counters 0, DVALID 0, flags 0, OVR 0. sSIN low after CLEAR restarts start detection.
- RXCLK while RST is asserted is ignored. Reset mid-frame discards the frame.

Test Plan:
- 8N1 0xA5, OVERSAMPLE=16, RXCLK every 4 CLK, DREADY=1 -> DVALID once, DOUT=0x0A5, PE=FE=BI=0, OVR never asserted.
- WLEN=7, PMODE=2 (even), send 0x41 with parity bit 1 -> DOUT=0x041, PE=1, FE=0; repeat with parity bit 0 -> PE=0.
- WLEN=9, STOP2=1, send 0x1FF with second stop bit 0 -> DOUT=0x1FF, FE=1, BI=0; with STOP2=0, same frame -> FE=0.
- SIN held low for 3 frame times, PMODE=0 -> one word DOUT=0, BI=1, FE=1; no second word until SIN high, then 0x55 received cleanly.
- DREADY=0, send 0x11 then 0x22 -> DOUT stays 0x011, OVR pulses one CLK at end of second frame; DREADY=1 -> DVALID drops.
- SIN low pulse of 5 ticks (false start) -> no DVALID, returns to IDLE; CLEAR mid-DATA -> BUSY=0 next CLK, no word delivered.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receive engine.
//   CLK, RST            clock, asynchronous active-high reset
//   RXCLK               oversample tick (OVERSAMPLE per bit)
//   CLEAR               synchronous abort, empties the output register
//   WLEN, PMODE, STOP2  frame format, latched at start-bit detection
//   SIN                 asynchronous serial input
//   DOUT, DVALID, DREADY, PE, FE, BI   valid/ready holding register and flags
//   OVR                 one-cycle pulse when a completed frame is dropped
//   BUSY                receiver not idle
module uart_rx_param #(
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RXCLK,
  input  logic                     CLEAR,
  input  logic [4:0]               WLEN,
  input  logic [2:0]               PMODE,
  input  logic                     STOP2,
  input  logic                     SIN,
  output logic [MAX_DATA_BITS-1:0] DOUT,
  output logic                     DVALID,
  input  logic                     DREADY,
  output logic                     PE,
  output logic                     FE,
  output logic                     BI,
  output logic                     OVR,
  output logic                     BUSY
);

  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam int unsigned DW  = MAX_DATA_BITS;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, STOP_B, BRK_WAIT
  } state_t;

  state_t              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]       tick_q;
  logic [4:0]          bit_q;
  logic [4:0]          wlen_q;
  logic [2:0]          pmode_q;
  logic                stop2_q;
  logic [1:0]          samp_q;
  logic [DW-1:0]       shadow_q;
  logic                par_q;
  logic                stop1_q;

  logic                ssin;
  logic [4:0]          wlen_c;
  logic                maj_c;
  logic                dec_c;
  logic                wrap_c;
  logic                par_en_c;
  logic                first_stop_c;
  logic                done_c;
  logic                pe_c;
  logic                fe_c;
  logic                bi_c;

  assign ssin = sync_q[SYNC_STAGES-1];

  // Clamp the requested word length into the supported range.
  always_comb begin
    wlen_c = WLEN;
    if (WLEN < 5'd5)
      wlen_c = 5'd5;
    else if (WLEN > 5'(MAX_DATA_BITS))
      wlen_c = 5'(MAX_DATA_BITS);
  end

  // Bit decision, frame completion and error evaluation for the current frame.
  always_comb begin
    maj_c        = (samp_q[0] & samp_q[1]) | (samp_q[0] & ssin) | (samp_q[1] & ssin);
    dec_c        = RXCLK && (tick_q == TW'(MID + 1));
    wrap_c       = RXCLK && (tick_q == TW'(OVERSAMPLE - 1));
    par_en_c     = (pmode_q >= 3'd1) && (pmode_q <= 3'd4);
    // In STOP the first stop decision is being made this cycle; afterwards it is stored.
    first_stop_c = (state_q == STOP) ? maj_c : stop1_q;
    done_c       = dec_c && (((state_q == STOP) && !stop2_q) || (state_q == STOP_B));
    fe_c         = !first_stop_c || ((state_q == STOP_B) && !maj_c);
    bi_c         = (shadow_q == '0) && !(par_en_c && par_q) && !first_stop_c;
    case (pmode_q)
      3'd1:    pe_c = !((^shadow_q) ^ par_q);
      3'd2:    pe_c = (^shadow_q) ^ par_q;
      3'd3:    pe_c = !par_q;
      3'd4:    pe_c = par_q;
      default: pe_c = 1'b0;
    endcase
  end

  // Synchroniser, receive FSM and output holding register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q   <= '1;
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      wlen_q   <= 5'd8;
      pmode_q  <= '0;
      stop2_q  <= 1'b0;
      samp_q   <= '1;
      shadow_q <= '0;
      par_q    <= 1'b0;
      stop1_q  <= 1'b1;
      DOUT     <= '0;
      DVALID   <= 1'b0;
      PE       <= 1'b0;
      FE       <= 1'b0;
      BI       <= 1'b0;
      OVR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIN};
      OVR    <= 1'b0;

      if (CLEAR) begin
        state_q <= IDLE;
        tick_q  <= '0;
        bit_q   <= '0;
        DVALID  <= 1'b0;
        PE      <= 1'b0;
        FE      <= 1'b0;
        BI      <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        // Tick counter runs only while a frame is being sampled.
        if (RXCLK && (state_q != IDLE) && (state_q != BRK_WAIT)) begin
          tick_q <= wrap_c ? '0 : tick_q + TW'(1);
          if (tick_q == TW'(MID - 1)) samp_q[0] <= ssin;
          if (tick_q == TW'(MID))     samp_q[1] <= ssin;
        end

        case (state_q)
          IDLE: begin
            tick_q <= '0;
            bit_q  <= '0;
            if (!ssin) begin
              state_q  <= START;
              BUSY     <= 1'b1;
              wlen_q   <= wlen_c;
              pmode_q  <= PMODE;
              stop2_q  <= STOP2;
              shadow_q <= '0;
              par_q    <= 1'b0;
              stop1_q  <= 1'b1;
            end
          end
          START: begin
            if (dec_c && maj_c) begin
              state_q <= IDLE;
              BUSY    <= 1'b0;
            end else if (wrap_c) begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
          DATA: begin
            if (dec_c) begin
              for (int i = 0; i < DW; i++)
                if (bit_q == 5'(i)) shadow_q[i] <= maj_c;
            end
            if (wrap_c) begin
              if (bit_q == wlen_q - 5'd1) begin
                bit_q   <= '0;
                state_q <= par_en_c ? PARITY : STOP;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end
          PARITY: begin
            if (dec_c)  par_q   <= maj_c;
            if (wrap_c) state_q <= STOP;
          end
          STOP: begin
            if (dec_c) stop1_q <= maj_c;
            if (done_c) begin
              state_q <= bi_c ? BRK_WAIT : IDLE;
              BUSY    <= bi_c;
            end else if (wrap_c && stop2_q) begin
              state_q <= STOP_B;
            end
          end
          STOP_B: begin
            if (done_c) begin
              state_q <= bi_c ? BRK_WAIT : IDLE;
              BUSY    <= bi_c;
            end
          end
          BRK_WAIT: begin
            tick_q <= '0;
            if (ssin) begin
              state_q <= IDLE;
              BUSY    <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            BUSY    <= 1'b0;
          end
        endcase

        // Holding register: load when empty or being drained, else report overrun.
        if (done_c && (!DVALID || DREADY)) begin
          DOUT   <= shadow_q;
          PE     <= pe_c;
          FE     <= fe_c;
          BI     <= bi_c;
          DVALID <= 1'b1;
        end else if (done_c) begin
          OVR <= 1'b1;
        end else if (DVALID && DREADY) begin
          DVALID <= 1'b0;
        end
      end
    end
  end

endmodule
